// File: rtl/axi4_lite_req_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of an AXI4-Lite master.
// One command in flight; completion or timeout is returned as a one-cycle ack.
module axi4_lite_req_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ack,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_timeout,
    output logic [1:0]              grant,
    output logic                    busy,
    output logic                    m_wr_en,
    output logic                    m_rd_en,
    output logic [ADDR_WIDTH-1:0]   m_write_address,
    output logic [DATA_WIDTH-1:0]   m_write_data,
    output logic [ADDR_WIDTH-1:0]   m_read_address,
    input  logic                    m_wr_done,
    input  logic                    m_rd_done,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  owner_q;
    logic                  last_grant_q;
    logic                  wr_q;
    logic                  timeout_q;
    logic [TW-1:0]         timer_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] waddr_q, raddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  sel;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  match_done;
    logic                  expired;

    // On a tie the requester not served last wins.
    assign sel       = (&req_valid) ? ~last_grant_q : req_valid[1];
    assign sel_write = sel ? req_write[1] : req_write[0];
    assign sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : req_wdata[DATA_WIDTH-1:0];

    assign match_done = wr_q ? m_wr_done : m_rd_done;
    assign expired    = (timer_q == TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (|req_valid) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (match_done || expired) state_d = RESP;
            RESP:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            timeout_q    <= 1'b0;
            timer_q      <= '0;
            rdata_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            raddr_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        owner_q <= sel;
                        wr_q    <= sel_write;
                        if (sel_write) begin
                            waddr_q <= sel_addr;
                            wdata_q <= sel_wdata;
                        end else begin
                            raddr_q <= sel_addr;
                        end
                    end
                end
                ISSUE: timer_q <= '0;
                WAIT: begin
                    // A done in the final WAIT cycle beats the timeout.
                    if (match_done) begin
                        if (!wr_q) rdata_q <= m_rdata;
                        timeout_q <= 1'b0;
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RESP: last_grant_q <= owner_q;
            endcase
        end
    end

    always_comb begin
        req_ack     = 2'b00;
        rsp_timeout = 1'b0;
        grant       = 2'b00;
        busy        = 1'b0;
        m_wr_en     = 1'b0;
        m_rd_en     = 1'b0;
        unique case (state_q)
            IDLE: ;
            ISSUE: begin
                busy    = 1'b1;
                grant   = owner_q ? 2'b10 : 2'b01;
                m_wr_en = wr_q;
                m_rd_en = !wr_q;
            end
            WAIT: begin
                busy  = 1'b1;
                grant = owner_q ? 2'b10 : 2'b01;
            end
            RESP: begin
                busy        = 1'b1;
                grant       = owner_q ? 2'b10 : 2'b01;
                req_ack     = owner_q ? 2'b10 : 2'b01;
                rsp_timeout = timeout_q;
            end
        endcase
    end

    assign rsp_rdata       = rdata_q;
    assign m_write_address = waddr_q;
    assign m_write_data    = wdata_q;
    assign m_read_address  = raddr_q;

endmodule
